// File: rtl/floating_point_stim_gen.sv
// Floating-point operand stimulus generator: table, xorshift64 and IEEE-754 special-value
// sources delivered over a valid/ready stream with a start/done run handshake.
module floating_point_stim_gen #(
    parameter int          EXP_WIDTH = 8,
    parameter int          MAN_WIDTH = 23,
    parameter int          NUM_CH    = 2,
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [63:0] LFSR_SEED = 64'h1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [1:0]                                mode,
    input  logic [15:0]                               num_vec,
    input  logic                                      wr_en,
    input  logic [1:0]                                wr_ch,
    input  logic [ADDR_W-1:0]                         wr_addr,
    input  logic [1+EXP_WIDTH+MAN_WIDTH-1:0]          wr_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NUM_CH*(1+EXP_WIDTH+MAN_WIDTH)-1:0] dout,
    output logic [15:0]                               vec_idx,
    output logic                                      busy,
    output logic                                      done
);

    localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [EXP_WIDTH-1:0] EXP_MAX  = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [EXP_WIDTH-1:0] EXP_BIAS = {1'b0, {(EXP_WIDTH-1){1'b1}}};
    localparam logic [MAN_WIDTH-1:0] MAN_ONES = '1;
    localparam logic [MAN_WIDTH-1:0] MAN_ZERO = '0;
    localparam logic [MAN_WIDTH-1:0] MAN_QNAN = {1'b1, {(MAN_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [1:0]  mode_q;
    logic [15:0] num_q;
    logic [W-1:0]  table_mem [NUM_CH][DEPTH];
    logic [63:0]   lfsr      [NUM_CH];
    logic [63:0]   lfsr_adv  [NUM_CH];
    logic [1:0]    load_mode;
    logic [15:0]   load_idx;
    logic [NUM_CH*W-1:0] next_vec;

    function automatic logic [63:0] xs_step(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    function automatic logic [W-1:0] special_val(input logic [2:0] k);
        logic [W-1:0] v;
        case (k)
            3'd0:    v = '0;
            3'd1:    v = {1'b1, {(W-1){1'b0}}};
            3'd2:    v = {1'b0, EXP_ONES, MAN_ZERO};
            3'd3:    v = {1'b1, EXP_ONES, MAN_ZERO};
            3'd4:    v = {1'b0, EXP_ONES, MAN_QNAN};
            3'd5:    v = {{(W-1){1'b0}}, 1'b1};
            3'd6:    v = {1'b0, EXP_MAX, MAN_ONES};
            default: v = {1'b0, EXP_BIAS, MAN_ZERO};
        endcase
        return v;
    endfunction

    // The vector that would be loaded next: vector 0 of a fresh run when idle, else the successor.
    always_comb begin
        load_mode = (state == IDLE) ? mode : mode_q;
        load_idx  = (state == IDLE) ? 16'd0 : vec_idx + 16'd1;
        next_vec  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lfsr_adv[c] = xs_step((state == IDLE) ? (LFSR_SEED + 64'(c)) : lfsr[c]);
            case (load_mode)
                2'd1:    next_vec[c*W +: W] = lfsr_adv[c][W-1:0];
                2'd2:    next_vec[c*W +: W] = special_val(load_idx[2:0] + 3'(c));
                default: next_vec[c*W +: W] = table_mem[c][load_idx[ADDR_W-1:0]];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int a = 0; a < DEPTH; a++)
                    table_mem[c][a] <= '0;
        end else if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++)
                if (wr_ch == 2'(c))
                    table_mem[c][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            num_q     <= 16'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dout      <= '0;
            vec_idx   <= 16'd0;
            for (int c = 0; c < NUM_CH; c++)
                lfsr[c] <= LFSR_SEED + 64'(c);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        num_q  <= num_vec;
                        busy   <= 1'b1;
                        for (int c = 0; c < NUM_CH; c++)
                            lfsr[c] <= (mode == 2'd1) ? lfsr_adv[c] : (LFSR_SEED + 64'(c));
                        if (num_vec != 16'd0) begin
                            dout      <= next_vec;
                            vec_idx   <= load_idx;
                            out_valid <= 1'b1;
                            state     <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (vec_idx == num_q - 16'd1) begin
                            out_valid <= 1'b0;
                            state     <= DONE;
                        end else begin
                            vec_idx <= load_idx;
                            dout    <= next_vec;
                            if (mode_q == 2'd1)
                                for (int c = 0; c < NUM_CH; c++)
                                    lfsr[c] <= lfsr_adv[c];
                        end
                    end
                end
                default: begin
                    // done is registered, so it pulses in the first idle cycle as busy drops
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_stim_gen.sv
// Directed self-checking bench for floating_point_stim_gen (single precision, two channels).
module tb_floating_point_stim_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] num_vec;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;
    logic [15:0] vec_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] table_exp [6];
    logic [31:0] stall_exp [4];
    logic [31:0] spec_exp  [8];

    floating_point_stim_gen #(
        .EXP_WIDTH(8), .MAN_WIDTH(23), .NUM_CH(2), .DEPTH(16), .ADDR_W(4), .LFSR_SEED(64'h1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vec(num_vec),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .vec_idx(vec_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic write_entry(input logic [1:0] ch, input logic [3:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic launch(input logic [1:0] m, input logic [15:0] n);
        mode    = m;
        num_vec = n;
        start   = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the edge that accepted the last vector.
    task automatic finish_run(input string tag);
        check({tag, "_valid_low"}, 64'(out_valid), 64'd0);
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        check({tag, "_done_early"}, 64'(done), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd1);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        table_exp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h0, 32'h0};
        stall_exp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h41000000};
        spec_exp  = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                      32'h7FC00000, 32'h00000001, 32'h7F7FFFFF, 32'h3F800000};
        rst = 1'b1; start = 1'b0; mode = 2'd0; num_vec = 16'd0;
        wr_en = 1'b0; wr_ch = 2'd0; wr_addr = 4'd0; wr_data = 32'd0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_idx", 64'(vec_idx), 64'd0);
        rst = 1'b0;
        tick();

        // Table mode, wrap into never-written entries
        write_entry(2'd0, 4'd0, 32'h3F800000);
        write_entry(2'd0, 4'd1, 32'h40000000);
        write_entry(2'd0, 4'd2, 32'h40400000);
        write_entry(2'd0, 4'd3, 32'h40800000);
        write_entry(2'd3, 4'd0, 32'hDEADBEEF);
        out_ready = 1'b1;
        launch(2'd0, 16'd6);
        check("tbl_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tbl_valid%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("tbl_idx%0d", i), 64'(vec_idx), 64'(i));
            check($sformatf("tbl_ch0_%0d", i), 64'(dout[31:0]), 64'(table_exp[i]));
            check($sformatf("tbl_ch1_%0d", i), 64'(dout[63:32]), 64'd0);
            tick();
        end
        finish_run("tbl");

        // Random mode: first advanced xorshift state of seeds 1 and 2, and reproducibility
        launch(2'd1, 16'd1);
        check("rnd_ch0", 64'(dout[31:0]), 64'h40822041);
        check("rnd_ch1", 64'(dout[63:32]), 64'h81044082);
        tick();
        finish_run("rnd");
        launch(2'd1, 16'd2);
        check("rnd_repeat_ch0", 64'(dout[31:0]), 64'h40822041);
        tick();
        check("rnd_second_ch0", 64'(dout[31:0]), 64'h0C011441);
        check("rnd_second_idx", 64'(vec_idx), 64'd1);
        tick();
        finish_run("rnd2");

        // Special-value sweep, channel 1 offset by one entry
        launch(2'd2, 16'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("spc_ch0_%0d", i), 64'(dout[31:0]), 64'(spec_exp[i]));
            check($sformatf("spc_ch1_%0d", i), 64'(dout[63:32]), 64'(spec_exp[(i + 1) % 8]));
            tick();
        end
        finish_run("spc");

        // Stalls, ignored start, writes during a run
        out_ready = 1'b0;
        launch(2'd0, 16'd4);
        mode  = 2'd2;
        start = 1'b1;
        write_entry(2'd0, 4'd0, 32'hC0000000);
        start = 1'b0;
        check("wr_no_disturb", 64'(dout[31:0]), 64'h3F800000);
        write_entry(2'd0, 4'd3, 32'h41000000);
        check("start_ignored_idx", 64'(vec_idx), 64'd0);
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            tick();
            check($sformatf("stall_a_idx%0d", i), 64'(vec_idx), 64'(i));
            check($sformatf("stall_a_dout%0d", i), 64'(dout[31:0]), 64'(stall_exp[i]));
            tick();
            check($sformatf("stall_b_idx%0d", i), 64'(vec_idx), 64'(i));
            check($sformatf("stall_b_dout%0d", i), 64'(dout[31:0]), 64'(stall_exp[i]));
            check($sformatf("stall_valid%0d", i), 64'(out_valid), 64'd1);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("stall_last_idx", 64'(vec_idx), 64'd3);
        finish_run("stall");

        // Empty run
        launch(2'd0, 16'd0);
        check("zero_valid0", 64'(out_valid), 64'd0);
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_done0", 64'(done), 64'd0);
        tick();
        check("zero_done1", 64'(done), 64'd1);
        check("zero_valid1", 64'(out_valid), 64'd0);
        tick();
        check("zero_done2", 64'(done), 64'd0);

        // Asynchronous reset mid-run clears the table
        launch(2'd0, 16'd6);
        check("mid_valid", 64'(out_valid), 64'd1);
        check("mid_dout", 64'(dout[31:0]), 64'hC0000000);
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_dout", dout, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        launch(2'd0, 16'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clr_idx%0d", i), 64'(vec_idx), 64'(i));
            check($sformatf("clr_dout%0d", i), dout, 64'd0);
            tick();
        end
        finish_run("clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
